// File: rtl/crack_dispatch.sv
// crack_dispatch: enumerates lowercase candidates, dispatches them to free hash cores, reports first match or exhaustion
module crack_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int MAX_LEN   = 8,
    parameter int DIGEST_W  = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [3:0]                      max_len_cfg,
    input  logic [DIGEST_W-1:0]             target_digest,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [NUM_CORES*MAX_LEN*8-1:0]  core_data,
    output logic [NUM_CORES*64-1:0]         core_len,
    input  logic [NUM_CORES-1:0]            core_done,
    input  logic [NUM_CORES*DIGEST_W-1:0]   core_digest,
    output logic                            busy,
    output logic                            found,
    output logic [MAX_LEN*8-1:0]            found_data,
    output logic [3:0]                      found_len,
    output logic                            exhausted,
    output logic                            overflow_err,
    output logic [31:0]                     cand_count
);
    localparam int DW = MAX_LEN * 8;
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t              state;
    logic [DIGEST_W-1:0] target;
    logic [DW-1:0]       gen_data, gen_next;
    logic [3:0]          gen_len, len_next, cfg_len;
    logic                gen_empty, wrap, any_free, cfg_ok;
    logic [NUM_CORES-1:0] core_busy, stale, hit;
    logic [IW-1:0]       hit_idx, free_idx;

    assign busy   = state == RUN;
    assign cfg_ok = max_len_cfg != 4'd0 && max_len_cfg <= 4'(MAX_LEN);

    // match detection and lowest-index free core; cores launched by an earlier search (stale) never match
    always_comb begin
        hit      = '0;
        hit_idx  = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            hit[i] = core_done[i] && core_busy[i] && !stale[i] &&
                     core_digest[i*DIGEST_W +: DIGEST_W] == target;
            if (hit[i]) hit_idx = IW'(i);
            if (!core_busy[i]) begin
                free_idx = IW'(i);
                any_free = 1'b1;
            end
        end
    end

    // next candidate: ripple 'z'->'a' carry from the last char; carry out of the first char grows the length
    always_comb begin
        gen_next = gen_data;
        len_next = gen_len;
        wrap     = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (wrap && 4'(k) < gen_len) begin
                wrap = gen_data[k*8 +: 8] == "z";
                gen_next[k*8 +: 8] = wrap ? "a" : gen_data[k*8 +: 8] + 8'd1;
            end
        end
        if (wrap) begin
            len_next = gen_len + 4'd1;
            for (int k = 0; k < MAX_LEN; k++)
                gen_next[k*8 +: 8] = 4'(k) <= gen_len ? "a" : 8'h00;
        end
    end

    // control FSM, core bookkeeping, dispatch and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            target       <= '0;
            gen_data     <= '0;
            gen_len      <= '0;
            cfg_len      <= '0;
            gen_empty    <= 1'b0;
            core_busy    <= '0;
            stale        <= '0;
            core_start   <= '0;
            core_data    <= '0;
            core_len     <= '0;
            found        <= 1'b0;
            found_data   <= '0;
            found_len    <= '0;
            exhausted    <= 1'b0;
            overflow_err <= 1'b0;
            cand_count   <= '0;
        end else begin
            core_start <= '0;
            core_busy  <= core_busy & ~core_done;
            stale      <= stale & ~core_done;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state        <= cfg_ok ? RUN : ERR;
                    overflow_err <= !cfg_ok;
                    found        <= 1'b0;
                    found_data   <= '0;
                    found_len    <= '0;
                    exhausted    <= 1'b0;
                    cand_count   <= '0;
                    target       <= target_digest;
                    cfg_len      <= max_len_cfg;
                    gen_data     <= DW'(8'h61);
                    gen_len      <= 4'd1;
                    gen_empty    <= 1'b0;
                    stale        <= core_busy & ~core_done;
                end
                RUN: if (|hit) begin
                    found      <= 1'b1;
                    found_data <= core_data[hit_idx*DW +: DW];
                    found_len  <= core_len[hit_idx*64 +: 4];
                    state      <= DONE;
                end else if (gen_empty && core_busy == '0) begin
                    exhausted <= 1'b1;
                    state     <= DONE;
                end else if (!gen_empty && any_free) begin
                    core_start[free_idx]         <= 1'b1;
                    core_data[free_idx*DW +: DW] <= gen_data;
                    core_len[free_idx*64 +: 64]  <= 64'(gen_len);
                    core_busy[free_idx]          <= 1'b1;
                    cand_count                   <= cand_count + 32'd1;
                    gen_data                     <= gen_next;
                    gen_len                      <= len_next;
                    gen_empty                    <= wrap && gen_len == cfg_len;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
